csel_sub_pipe: RTL and testbench

- 2-stage pipelined carry-select subtractor; the inverse-direction companion to the team's 32-bit carry-select adder (csa).
- Computes D = A − B − Bin with borrow-out and signed overflow.
- Uses a valid/ready handshake on both sides so it can sit in a streaming datapath or be driven by the adder bench's stimulus generator.

---
 rtl/csel_sub_pipe.sv | 140 ++++++++++++++
 tb/tb_csel_sub_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csel_sub_pipe.sv
// Two-stage pipelined carry-select subtractor: diff = a - b - bin, with borrow-out and signed overflow.
// Stage 1 resolves the low half and both speculative upper halves; stage 2 selects the upper half.
module csel_sub_pipe #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;
    localparam int NBLK = HALF / BLK;

    logic [WIDTH-1:0]  bn;
    logic [WIDTH-1:0]  psum0;
    logic [WIDTH-1:0]  psum1;
    logic [2*NBLK-1:0] pc0;
    logic [2*NBLK-1:0] pc1;

    logic [HALF-1:0] lo_sum;
    logic [HALF-1:0] hi_sum0;
    logic [HALF-1:0] hi_sum1;
    logic            lo_c;
    logic            hi_c0;
    logic            hi_c1;

    logic            s1_valid;
    logic [HALF-1:0] s1_lo;
    logic            s1_lc;
    logic [HALF-1:0] s1_hi0;
    logic [HALF-1:0] s1_hi1;
    logic            s1_hc0;
    logic            s1_hc1;
    logic            s1_am;
    logic            s1_bm;

    logic            s1_adv;
    logic            s2_adv;
    logic [HALF-1:0] hi_sel;
    logic            c_sel;

    assign bn = ~b;

    // Every BLK-wide slice computes its sum for both possible carry-ins up front.
    for (genvar k = 0; k < 2*NBLK; k++) begin : g_blk
        logic [BLK:0] r0;
        logic [BLK:0] r1;
        assign r0 = {1'b0, a[k*BLK +: BLK]} + {1'b0, bn[k*BLK +: BLK]};
        assign r1 = r0 + (BLK+1)'(1);
        assign psum0[k*BLK +: BLK] = r0[BLK-1:0];
        assign psum1[k*BLK +: BLK] = r1[BLK-1:0];
        assign pc0[k] = r0[BLK];
        assign pc1[k] = r1[BLK];
    end

    // Carry chains: the low half is driven by ~bin, the upper half is evaluated for both carry-ins.
    always_comb begin
        logic c;
        logic c0;
        logic c1;
        lo_sum  = '0;
        hi_sum0 = '0;
        hi_sum1 = '0;
        c  = ~bin;
        c0 = 1'b0;
        c1 = 1'b1;
        for (int k = 0; k < NBLK; k++) begin
            lo_sum[k*BLK +: BLK]  = c  ? psum1[k*BLK +: BLK] : psum0[k*BLK +: BLK];
            hi_sum0[k*BLK +: BLK] = c0 ? psum1[(NBLK+k)*BLK +: BLK] : psum0[(NBLK+k)*BLK +: BLK];
            hi_sum1[k*BLK +: BLK] = c1 ? psum1[(NBLK+k)*BLK +: BLK] : psum0[(NBLK+k)*BLK +: BLK];
            c  = c  ? pc1[k] : pc0[k];
            c0 = c0 ? pc1[NBLK+k] : pc0[NBLK+k];
            c1 = c1 ? pc1[NBLK+k] : pc0[NBLK+k];
        end
        lo_c  = c;
        hi_c0 = c0;
        hi_c1 = c1;
    end

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_lc    <= 1'b0;
            s1_hi0   <= '0;
            s1_hi1   <= '0;
            s1_hc0   <= 1'b0;
            s1_hc1   <= 1'b0;
            s1_am    <= 1'b0;
            s1_bm    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo  <= lo_sum;
                s1_lc  <= lo_c;
                s1_hi0 <= hi_sum0;
                s1_hi1 <= hi_sum1;
                s1_hc0 <= hi_c0;
                s1_hc1 <= hi_c1;
                s1_am  <= a[WIDTH-1];
                s1_bm  <= b[WIDTH-1];
            end
        end
    end

    assign hi_sel = s1_lc ? s1_hi1 : s1_hi0;
    assign c_sel  = s1_lc ? s1_hc1 : s1_hc0;

    // Output registers only reload on a real result, so they stay put while idle or stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                diff <= {hi_sel, s1_lo};
                bout <= ~c_sel;
                ovf  <= (s1_am != s1_bm) && (hi_sel[HALF-1] != s1_am);
            end
        end
    end

endmodule

// File: tb/tb_csel_sub_pipe.sv
// Bench for csel_sub_pipe: directed vectors plus a queue-based reference model checked every cycle.
module tb_csel_sub_pipe;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           tag;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic rst_pending = 1'b0;

    csel_sub_pipe #(.WIDTH(W), .BLK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide unsigned and signed arithmetic.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t         e;
        logic [W:0]   full;
        longint       r;
        longint       smax;
        full = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
        r    = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
        smax = (longint'(1) <<< (W-1)) - 1;
        e.d   = full[W-1:0];
        e.bo  = full[W];
        e.ov  = (r > smax) || (r < -smax - 1);
        e.tag = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        int   n;
        logic exp_ov;
        exp_t e;
        if (rst_pending) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_diff", diff, 0);
            check("rst_bout", bout, 0);
            check("rst_ovf", ovf, 0);
            check("rst_in_ready", in_ready, 1);
            rst_pending = 1'b0;
        end
        if (!rst_n) begin
            q.delete();
            rst_pending = 1'b1;
        end else begin
            n = q.size();
            check("model_in_ready", in_ready, (n < 2) || out_ready);
            exp_ov = (n > 0) && (cyc >= q[0].tag + 2);
            check("model_out_valid", out_valid, exp_ov);
            if (exp_ov && out_valid) begin
                check("model_diff", diff, q[0].d);
                check("model_bout", bout, q[0].bo);
                check("model_ovf", ovf, q[0].ov);
            end
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && in_ready) begin
                e = model(a, b, bin);
                e.tag = cyc;
                q.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the operands were accepted.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        int guard;
        guard = 0;
        a = ta;
        b = tb;
        bin = tbin;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] ed, input logic ebo,
                               input logic eov, input int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({name, "_seen"}, out_valid, 1);
        if (lat > 0) check({name, "_latency"}, n, lat);
        check({name, "_diff"}, diff, ed);
        check({name, "_bout"}, bout, ebo);
        check({name, "_ovf"}, ovf, eov);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string name);
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_drained"}, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   k;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        bin = 1'b0;

        e = model(32'h0000_0000, 32'h0000_0001, 1'b0);
        check("pin_wrap_d", e.d, 32'hFFFF_FFFF);
        check("pin_wrap_bo", e.bo, 1);
        e = model(32'h8000_0000, 32'h0000_0001, 1'b0);
        check("pin_ovf_d", e.d, 32'h7FFF_FFFF);
        check("pin_ovf_ov", e.ov, 1);
        check("pin_ovf_bo", e.bo, 0);

        // Test 1: reset then single op
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0);
        checkOutput("t1", 32'h0000_0002, 1'b0, 1'b0, 2);

        // Test 2: borrow and wrap
        applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b0);
        checkOutput("t2_wrap", 32'hFFFF_FFFF, 1'b1, 1'b0, 2);
        applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1);
        checkOutput("t2_bin", 32'hFFFF_FFFF, 1'b1, 1'b0, 2);

        // Test 3: signed overflow and cross-half select
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0);
        checkOutput("t3_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 2);
        applyStimulus(32'h0001_0000, 32'h0000_0001, 1'b0);
        checkOutput("t3_half", 32'h0000_FFFF, 1'b0, 1'b0, 2);
        applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkOutput("t3_negovf", 32'h8000_0000, 1'b1, 1'b1, 2);

        // Test 4: streaming
        for (int i = 0; i < 100; i++) begin
            a = W'(i);
            b = W'(i >> 1);
            bin = i[0];
            in_valid = 1'b1;
            @(negedge clk);
            check("stream_ready", in_ready, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        waitDrain("t4");

        // Test 5: backpressure
        out_ready = 1'b0;
        k = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            a = 32'h1000 + W'(k);
            b = W'(k);
            bin = 1'b0;
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk);
            #1;
        end
        check("bp_accepted", k, 2);
        @(negedge clk);
        check("bp_blocked", in_ready, 0);
        check("bp_front", diff, 32'h0000_1000);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        a = 32'h1000 + W'(k);
        b = W'(k);
        @(negedge clk);
        check("bp_resume", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitDrain("t5");

        // Test 6: reset mid-flight
        out_ready = 1'b0;
        applyStimulus(32'h0000_0009, 32'h0000_0001, 1'b0);
        applyStimulus(32'h0000_0008, 32'h0000_0001, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t6_no_ghost", out_valid, 0);
        end
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_0007, 32'h0000_0002, 1'b1);
        checkOutput("t6_after", 32'h0000_0004, 1'b0, 1'b0, 2);
        waitDrain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
